alu_equiv_driver: RTL and testbench
===================================

# alu_equiv_driver

Self-checking stimulus engine that drives the two-ALU equivalence harness (behavioural ALU vs. synthesized-netlist ALU) from the stimulus side. It generates pseudo-random operand/carry/opcode vectors from an LFSR and applies each vector identically to both ALU copies. It compares the two result/flag sets, counts mismatches and captures the first failing vector. It sits between the bench/board control logic (start, status LEDs) and the harness's a/b/c/op inputs and y/flags outputs.

## Interface
- NUM_VECTORS, 1024: vectors per run, 1..65535.
- SEED, 48'h0000_ACE1_2458: LFSR load value on every start. A SEED of 0 is replaced by 48'h1.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begins a run when sampled high in IDLE or DONE; ignored otherwise.
- a_out, b_out  out  16  operands, fanned to both ALUs.
- c_out  out  1  carry-in, fanned to both ALUs.
- op_out  out  8  opcode, fanned to both ALUs.
- y1, y2  in  16  results from the behavioural and synthesized ALU.
- flags1, flags2  in  5  {C,L,F,Z,N} from each ALU.
- busy  out  1  high in LOAD/CHECK.
- done  out  1  high in DONE.
- pass  out  1  done && err_count==0.
- err_count  out  16  mismatching vectors this run; saturates at 16'hFFFF.
- fail_valid  out  1  a first failure has been captured this run.
- fail_index  out  16  vector index (0-based) of the first failure.
- fail_a, fail_b  out  16  operands of the first failure.
- fail_c  out  1  carry of the first failure.
- fail_op  out  8  opcode of the first failure.

## Operation
- LFSR: 48-bit Fibonacci, taps 48,47,21,20 (XNOR-free XOR form). It shifts toward the MSB, and the new bit 0 is lfsr[47]^lfsr[46]^lfsr[20]^lfsr[19].
- Vector fields from the current LFSR value: a=lfsr[15:0], b=lfsr[31:16], op=lfsr[39:32], c=lfsr[40].
- FSM states: IDLE, LOAD, CHECK, DONE.
  - IDLE/DONE with start=1: lfsr<=SEED, vec_idx<=0, err_count<=0, fail_* <= 0, fail_valid<=0, then go to LOAD.
  - LOAD: register the vector fields into a_out/b_out/c_out/op_out, then go to CHECK.
  - CHECK: ALUs are combinational and outputs are compared this cycle. A mismatch is (y1!=y2) || (flags1!=flags2).
    - On a mismatch, err_count increments (saturating).
    - On a mismatch with fail_valid=0, capture vec_idx and the current a_out/b_out/c_out/op_out, and set fail_valid.
    - The LFSR steps once and vec_idx increments.
    - If vec_idx==NUM_VECTORS-1, go to DONE; otherwise go to LOAD.
  - DONE: hold all results and outputs until start or reset.
- Stimulus outputs hold their last value outside LOAD.
- Result registers are cleared only by reset or by a new start.

## Timing
- Reset value of every output: 0. The state resets to IDLE and lfsr resets to SEED, or 1 if SEED is 0.
- Each vector takes 2 cycles, with its CHECK one cycle after its LOAD.
- Edge E0 samples start. The stimulus for vector k is valid after edge E0+1+2k and is compared at edge E0+2+2k.
- done rises after edge E0+2·NUM_VECTORS; pass and err_count are valid in that same cycle.
- start while busy has no effect.
- reset asserted mid-run aborts immediately and asynchronously. It clears err_count and fail_*, and the block returns to IDLE.
- Mismatch on the last vector: the count and capture complete on the same edge that enters DONE.

## Test plan
- Clean run: y2=y1, flags2=flags1, NUM_VECTORS=8, start pulse at E0 -> busy for 16 cycles, done at E0+16, err_count=0, pass=1, fail_valid=0.
- Sequence check: SEED=48'h0000_ACE1_2458 -> first vector a=16'h2458, b=16'hACE1, op=8'h00, c=0. The second vector equals the fields after one LFSR step, checked against a bench reference LFSR.
- Stuck mismatch: flags2=flags1^5'b00001, NUM_VECTORS=8 -> err_count=8, pass=0, fail_valid=1, fail_index=0, fail_a=16'h2458, fail_b=16'hACE1.
- Single mismatch: y2=y1^16'h0001 only when vec_idx==5 -> err_count=1, fail_index=5, fail_a/b/c/op equal vector 5's fields.
- Start while busy: pulse start at cycle 5 of a run -> no restart, done still at E0+16. Start again in DONE -> err_count and fail_valid clear, and the run repeats with identical vectors.
- Reset mid-run: assert reset at cycle 7 -> all outputs 0 asynchronously, state IDLE. A subsequent start runs a full fresh sequence from SEED.

Source files
------------

// File: rtl/alu_equiv_driver.sv
// LFSR-driven stimulus engine for a two-ALU equivalence harness: applies each
// pseudo-random vector to both ALUs, compares results, counts and captures failures.
module alu_equiv_driver #(
    parameter int unsigned NUM_VECTORS = 1024,
    parameter logic [47:0] SEED        = 48'h0000_ACE1_2458
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] a_out,
    output logic [15:0] b_out,
    output logic        c_out,
    output logic [7:0]  op_out,
    input  logic [15:0] y1,
    input  logic [15:0] y2,
    input  logic [4:0]  flags1,
    input  logic [4:0]  flags2,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic        fail_valid,
    output logic [15:0] fail_index,
    output logic [15:0] fail_a,
    output logic [15:0] fail_b,
    output logic        fail_c,
    output logic [7:0]  fail_op
);

    // An all-zero state would lock the XOR-form LFSR, so it is never loaded.
    localparam logic [47:0] SEED_EFF = (SEED == 48'd0) ? 48'd1 : SEED;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

    state_t      state;
    logic [47:0] lfsr;
    logic [15:0] vec_idx;
    logic        mismatch;

    function automatic logic [47:0] lfsr_step(input logic [47:0] s);
        return {s[46:0], s[47] ^ s[46] ^ s[20] ^ s[19]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign mismatch = (y1 != y2) || (flags1 != flags2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            vec_idx    <= '0;
            a_out      <= '0;
            b_out      <= '0;
            c_out      <= 1'b0;
            op_out     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_index <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_c     <= 1'b0;
            fail_op    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr       <= SEED_EFF;
                        vec_idx    <= '0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_index <= '0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_c     <= 1'b0;
                        fail_op    <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    a_out  <= lfsr[15:0];
                    b_out  <= lfsr[31:16];
                    op_out <= lfsr[39:32];
                    c_out  <= lfsr[40];
                    state  <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= sat_inc(err_count);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_index <= vec_idx;
                            fail_a     <= a_out;
                            fail_b     <= b_out;
                            fail_c     <= c_out;
                            fail_op    <= op_out;
                        end
                    end
                    lfsr    <= lfsr_step(lfsr);
                    vec_idx <= vec_idx + 16'd1;
                    // pass must also see a mismatch on the final vector.
                    if (vec_idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == 16'd0);
                        state <= DONE;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_equiv_driver.sv
// Bench for alu_equiv_driver: a bench-side ALU pair with injectable mismatches
// and a reference LFSR vector list checked against every run.
module tb_alu_equiv_driver;

    localparam int NV = 8;
    localparam logic [47:0] SEED = 48'h0000_ACE1_2458;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_out, b_out, y1, y2, err_count, fail_index, fail_a, fail_b;
    logic        c_out, busy, done, pass, fail_valid, fail_c;
    logic [7:0]  op_out, fail_op;
    logic [4:0]  flags1, flags2;

    logic [7:0]  inj_mask = 8'h00;
    logic        inj_flags = 1'b0;
    logic        inject;
    int          cur_k = 0;

    int checks = 0;
    int errors = 0;

    logic [15:0] va [NV];
    logic [15:0] vb [NV];
    logic        vc [NV];
    logic [7:0]  vop [NV];

    alu_equiv_driver #(.NUM_VECTORS(NV), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .op_out(op_out),
        .y1(y1), .y2(y2), .flags1(flags1), .flags2(flags2),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .fail_index(fail_index),
        .fail_a(fail_a), .fail_b(fail_b), .fail_c(fail_c), .fail_op(fail_op)
    );

    always #5 clk = ~clk;

    // Reference ALU and a "netlist" copy that differs only on injected vectors.
    always_comb begin
        y1     = op_out[0] ? (a_out ^ b_out) : (a_out + b_out + {15'd0, c_out});
        flags1 = {c_out, a_out < b_out, op_out[7], y1 == 16'd0, y1[15]};
        inject = inj_mask[cur_k[2:0]];
        y2     = y1 ^ ((inject && !inj_flags) ? 16'h0001 : 16'h0000);
        flags2 = flags1 ^ ((inject && inj_flags) ? 5'b00001 : 5'b00000);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_model;
        logic [47:0] s;
        s = SEED;
        for (int k = 0; k < NV; k++) begin
            va[k]  = s[15:0];
            vb[k]  = s[31:16];
            vop[k] = s[39:32];
            vc[k]  = s[40];
            s = {s[46:0], s[47] ^ s[46] ^ s[20] ^ s[19]};
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_fv"}, fail_valid, 0);
        check({tag, "_fi"}, fail_index, 0);
        check({tag, "_fa"}, fail_a, 0);
        check({tag, "_fb"}, fail_b, 0);
        check({tag, "_fc"}, fail_c, 0);
        check({tag, "_fop"}, fail_op, 0);
        check({tag, "_a"}, a_out, 0);
        check({tag, "_b"}, b_out, 0);
        check({tag, "_c"}, c_out, 0);
        check({tag, "_op"}, op_out, 0);
    endtask

    task automatic run(input logic [7:0] mask, input logic flg, input bit start_busy);
        int exp_err;
        int first;
        exp_err = 0;
        first = -1;
        for (int k = 0; k < NV; k++) begin
            if (mask[k]) begin
                exp_err++;
                if (first < 0) first = k;
            end
        end
        inj_mask  = mask;
        inj_flags = flg;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_err_clr", err_count, 0);
        check("start_fv_clr", fail_valid, 0);
        check("start_busy", busy, 1);
        for (int k = 0; k < NV; k++) begin
            tick();
            cur_k = k;
            check("vec_a", a_out, va[k]);
            check("vec_b", b_out, vb[k]);
            check("vec_c", c_out, vc[k]);
            check("vec_op", op_out, vop[k]);
            check("run_busy", busy, 1);
            check("run_done", done, 0);
            if (k == 0) begin
                check("vec0_a", a_out, 16'h2458);
                check("vec0_b", b_out, 16'hACE1);
                check("vec0_op", op_out, 8'h00);
                check("vec0_c", c_out, 0);
            end
            if (start_busy && k == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_err", err_count, exp_err);
        check("end_pass", pass, exp_err == 0);
        check("end_fv", fail_valid, exp_err != 0);
        if (exp_err != 0) begin
            check("end_fi", fail_index, first);
            check("end_fa", fail_a, va[first]);
            check("end_fb", fail_b, vb[first]);
            check("end_fc", fail_c, vc[first]);
            check("end_fop", fail_op, vop[first]);
        end else begin
            check("end_fi0", fail_index, 0);
        end
        // DONE holds everything while idle.
        tick();
        tick();
        check("hold_done", done, 1);
        check("hold_err", err_count, exp_err);
        check("hold_a", a_out, va[NV-1]);
    endtask

    initial begin
        build_model();
        tick();
        tick();
        check_all_zero("rst");
        reset = 1'b0;
        tick();

        run(8'h00, 1'b0, 1'b0);          // clean run
        run(8'hFF, 1'b1, 1'b0);          // stuck flag mismatch
        run(8'h20, 1'b0, 1'b0);          // single mismatch at vector 5
        run(8'h00, 1'b0, 1'b1);          // start while busy, restart from DONE
        run(8'h80, 1'b0, 1'b0);          // mismatch on the last vector

        // Reset mid-run aborts asynchronously.
        inj_mask = 8'hFF;
        inj_flags = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        #2 reset = 1'b1;
        #1 check_all_zero("amid");
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        run(8'h00, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run(8'($urandom_range(0, 255)), 1'($urandom % 2), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
